// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/flush controller with stall watchdog
//
// Purpose: combines per-stage stall requests into a 6-bit hold vector,
// sequences a one-cycle flush on exceptions, and raises a sticky watchdog
// flag when the pipeline stays stalled for STALL_TIMEOUT consecutive cycles.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst              asynchronous reset, active low
//   i_stallreq_if      fetch-side wait request
//   i_stallreq_id      decode-side load-use hazard request
//   i_stallreq_ex      multi-cycle execute request
//   i_stallreq_mem     data-bus wait request
//   i_excpt            exception / flush request from mem stage
//   i_excpt_pc[31:0]   handler address, valid with i_excpt
//   o_stall[5:0]       per-stage hold: pc, if, id, ex, mem, wb (bit0..bit5)
//   o_flush            clear pipeline registers and redirect pc
//   o_flush_pc[31:0]   redirect target, valid with o_flush
//   o_stall_timeout    sticky watchdog flag
//   o_stall_cycles     cycles with any stage held (PIPE_CTRL_PERF_EN only)
//   o_flush_count      number of flush cycles (PIPE_CTRL_PERF_EN only)

module pipe_ctrl #(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stallreq_if,
    input  logic        i_stallreq_id,
    input  logic        i_stallreq_ex,
    input  logic        i_stallreq_mem,
    input  logic        i_excpt,
    input  logic [31:0] i_excpt_pc,
    output logic [5:0]  o_stall,
    output logic        o_flush,
    output logic [31:0] o_flush_pc,
    output logic        o_stall_timeout,
    output logic [31:0] o_stall_cycles,
    output logic [15:0] o_flush_count
);

    localparam logic [15:0] LP_TIMEOUT = 16'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  w_stall;
    logic        w_any_req;
    logic [15:0] r_wdog;
    logic [15:0] w_wdog_inc;
    logic        r_timeout;
    logic [31:0] r_flush_pc;

    assign w_any_req = i_stallreq_if | i_stallreq_id | i_stallreq_ex | i_stallreq_mem;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The most downstream requesting stage wins: holding a stage also holds
    // everything upstream of it.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 6'b000000;
        case (r_state)
            ST_RUN, ST_STALL: begin
                if (i_stallreq_mem) begin
                    w_stall = 6'b011111;
                end else if (i_stallreq_ex) begin
                    w_stall = 6'b001111;
                end else if (i_stallreq_id) begin
                    w_stall = 6'b000111;
                end else if (i_stallreq_if) begin
                    w_stall = 6'b000011;
                end
                if (i_excpt) begin
                    w_state_next = ST_FLUSH;
                end else if (w_any_req) begin
                    w_state_next = ST_STALL;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Requests and exceptions arriving during the flush are dropped.
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // The encoder would otherwise pass live requests through while reset is held.
    assign o_stall = i_rst ? w_stall : 6'b000000;
    assign o_flush = (r_state == ST_FLUSH);

    assign w_wdog_inc = (r_wdog == 16'hFFFF) ? r_wdog : r_wdog + 16'd1;

    // Watchdog counts consecutive stalled cycles as they complete, so the flag
    // becomes visible in the cycle after the STALL_TIMEOUT-th stalled cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wdog     <= 16'd0;
            r_timeout  <= 1'b0;
            r_flush_pc <= 32'h0;
        end else begin
            if (w_state_next == ST_STALL) begin
                r_wdog <= w_wdog_inc;
                if (w_wdog_inc >= LP_TIMEOUT) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wdog <= 16'd0;
            end
            if (w_state_next == ST_FLUSH) begin
                r_timeout  <= 1'b0;
                r_flush_pc <= i_excpt_pc;
            end
        end
    end

    assign o_flush_pc      = r_flush_pc;
    assign o_stall_timeout = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if ((o_stall != 6'b000000) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if ((r_state == ST_FLUSH) && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`else
    assign o_stall_cycles = 32'd0;
    assign o_flush_count  = 16'd0;
`endif

endmodule
